// File: rtl/pipeline_trace_tagger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared types and constants for the pipeline trace tagger.
//             Defines the per-slot tag record, the stage enumeration, the
//             empty-slot constant and a saturating stall-counter helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

    localparam int PC_W       = 16;   // PC and instruction width
    localparam int SEQ_W      = 8;    // sequence number width (wraps)
    localparam int CYC_W      = 32;   // cycle counter width
    localparam int STL_W      = 3;    // per-instruction stall counter width
    localparam int NUM_STAGES = 5;
    localparam int STL_MAX    = (1 << STL_W) - 1;

    typedef struct packed {
        logic             valid;
        logic [SEQ_W-1:0] seq;
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  instr;
        logic [CYC_W-1:0] fetch_cyc;
        logic [STL_W-1:0] stalls;
    } trace_slot_t;

    typedef enum logic [2:0] {
        IF  = 3'd0,
        ID  = 3'd1,
        EX  = 3'd2,
        MEM = 3'd3,
        WB  = 3'd4
    } stage_t;

    localparam trace_slot_t BUBBLE = '0;

    // Stall counter sticks at its maximum instead of wrapping.
    function automatic logic [STL_W-1:0] stall_sat_inc(input logic [STL_W-1:0] s);
        return (s == STL_W'(STL_MAX)) ? s : s + STL_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_trace_tagger_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_trace_tagger_if
//  Purpose  : Bundles the fetch/hazard inputs and retire/status outputs of
//             the pipeline trace tagger.
//  Ports    : master - drives fetch_en/fetch_pc/fetch_instr/stall/flush,
//                      observes retire_* and status counters
//             slave  - the tagger side (opposite directions)
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_trace_tagger_if;
    import trace_pkg::*;

    logic             fetch_en;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  fetch_instr;
    logic             stall;
    logic             flush;

    logic             retire_valid;
    logic [SEQ_W-1:0] retire_seq;
    logic [PC_W-1:0]  retire_pc;
    logic [PC_W-1:0]  retire_instr;
    logic [CYC_W-1:0] retire_fetch_cyc;
    logic [CYC_W-1:0] retire_cyc;
    logic [STL_W-1:0] retire_stalls;
    logic [CYC_W-1:0] cycle_count;
    logic [2:0]       in_flight;
    logic [CYC_W-1:0] retired_count;

    modport master (
        output fetch_en, fetch_pc, fetch_instr, stall, flush,
        input  retire_valid, retire_seq, retire_pc, retire_instr,
               retire_fetch_cyc, retire_cyc, retire_stalls,
               cycle_count, in_flight, retired_count
    );

    modport slave (
        input  fetch_en, fetch_pc, fetch_instr, stall, flush,
        output retire_valid, retire_seq, retire_pc, retire_instr,
               retire_fetch_cyc, retire_cyc, retire_stalls,
               cycle_count, in_flight, retired_count
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_trace_tagger_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_stage_reg
//  Purpose  : One pipeline slot holding an instruction tag.
//             Priority: rst > stall_hold > bubble > load > hold.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             load         - capture d
//             bubble       - clear to an empty slot
//             stall_hold   - keep contents, bump stall counter if valid
//             d / q        - incoming / current slot record
//  Revision : 1.0  initial release
// ============================================================================
module trace_stage_reg
    import trace_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load,
    input  wire logic        bubble,
    input  wire logic        stall_hold,
    input  wire trace_slot_t d,
    output trace_slot_t      q
);

    trace_slot_t r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= BUBBLE;
        end else if (stall_hold) begin
            // Empty slots stay all-zero so bubbles never accumulate stalls.
            if (r_slot.valid) begin
                r_slot.stalls <= stall_sat_inc(r_slot.stalls);
            end
        end else if (bubble) begin
            r_slot <= BUBBLE;
        end else if (load) begin
            r_slot <= d;
        end
    end

    assign q = r_slot;

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_tagger.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_trace_tagger
//  Purpose  : Tags each fetched instruction with a sequence number and fetch
//             cycle, shadows it through IF/ID/EX/MEM/WB in lock-step with the
//             CPU pipeline (honouring stall and flush) and presents a retire
//             record when it reaches WB.
//  Ports    : clk, rst - clock, synchronous active-high reset
//             bus      - slave side of pipeline_trace_tagger_if
//                        (fetch/stall/flush in, retire record and
//                        cycle_count / in_flight / retired_count out)
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_trace_tagger
    import trace_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    pipeline_trace_tagger_if.slave bus
);

    trace_slot_t      w_slot   [NUM_STAGES];
    trace_slot_t      w_d      [NUM_STAGES];
    logic             w_load   [NUM_STAGES];
    logic             w_bubble [NUM_STAGES];
    logic             w_hold   [NUM_STAGES];

    trace_slot_t      w_new;
    logic             w_capture;
    logic [2:0]       w_in_flight;

    logic [SEQ_W-1:0] r_next_seq;
    logic [CYC_W-1:0] r_cycle_count;
    logic [CYC_W-1:0] r_retired_count;

    // A stall freezes fetch, so the sequence number only advances when
    // an instruction is actually captured into IF.
    assign w_capture = bus.fetch_en && !bus.stall;

    always_comb begin
        w_new           = BUBBLE;
        w_new.valid     = 1'b1;
        w_new.seq       = r_next_seq;
        w_new.pc        = bus.fetch_pc;
        w_new.instr     = bus.fetch_instr;
        w_new.fetch_cyc = r_cycle_count;
        w_new.stalls    = '0;
    end

    // Slot steering. The stage register resolves priority, so stall wins
    // over flush in IF/ID without extra gating here.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_d[i]      = BUBBLE;
            w_load[i]   = 1'b1;
            w_bubble[i] = 1'b0;
            w_hold[i]   = 1'b0;
        end

        w_d[IF]      = w_new;
        w_hold[IF]   = bus.stall;
        w_bubble[IF] = !bus.fetch_en;

        w_d[ID]      = w_slot[IF];
        w_hold[ID]   = bus.stall;
        w_bubble[ID] = bus.flush;

        w_d[EX]      = w_slot[ID];
        w_bubble[EX] = bus.stall;

        w_d[MEM]     = w_slot[EX];
        w_d[WB]      = w_slot[MEM];
    end

    generate
        for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
            trace_stage_reg u_slot (
                .clk        (clk),
                .rst        (rst),
                .load       (w_load[i]),
                .bubble     (w_bubble[i]),
                .stall_hold (w_hold[i]),
                .d          (w_d[i]),
                .q          (w_slot[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_seq      <= '0;
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + CYC_W'(1);
            if (w_capture) begin
                r_next_seq <= r_next_seq + SEQ_W'(1);
            end
            if (w_slot[WB].valid) begin
                r_retired_count <= r_retired_count + CYC_W'(1);
            end
        end
    end

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_in_flight = w_in_flight + 3'(w_slot[i].valid);
        end
    end

    // Retire data is zeroed when WB is empty so the printer never sees
    // stale fields.
    assign bus.retire_valid     = w_slot[WB].valid;
    assign bus.retire_seq       = w_slot[WB].valid ? w_slot[WB].seq       : '0;
    assign bus.retire_pc        = w_slot[WB].valid ? w_slot[WB].pc        : '0;
    assign bus.retire_instr     = w_slot[WB].valid ? w_slot[WB].instr     : '0;
    assign bus.retire_fetch_cyc = w_slot[WB].valid ? w_slot[WB].fetch_cyc : '0;
    assign bus.retire_cyc       = w_slot[WB].valid ? r_cycle_count        : '0;
    assign bus.retire_stalls    = w_slot[WB].valid ? w_slot[WB].stalls    : '0;
    assign bus.cycle_count      = r_cycle_count;
    assign bus.in_flight        = w_in_flight;
    assign bus.retired_count    = r_retired_count;

endmodule
`default_nettype wire

// File: doc/pipeline_trace_tagger.md
# pipeline_trace_tagger

Synthesizable instruction-tracking block that tags every fetched instruction with a sequence number and cycle stamp and carries that tag through the five CPU stages (IF, ID, EX, MEM, WB) in lock-step with the real pipeline, honouring stall and flush. It sits directly upstream of the testbench pipeline printer. Its per-instruction retire record (seq, PC, instruction, fetch/retire cycle, stall count) is what the printer consumes to report completed instructions, instead of inferring stage occupancy itself.

## Interface
- PC_W, 16, PC and instruction width
- SEQ_W, 8, sequence-number width (wraps)
- CYC_W, 32, cycle-counter width
- STL_W, 3, per-instruction stall-counter width (saturating)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_en  in  1  a real instruction is presented at fetch this cycle
- fetch_pc  in  PC_W  PC of fetched instruction
- fetch_instr  in  PC_W  fetched instruction word
- stall  in  1  hazard stall: IF and ID hold, bubble into EX
- flush  in  1  taken branch resolved in ID: squash the instruction in IF
- retire_valid  out  1  WB slot holds a real instruction this cycle
- retire_seq  out  SEQ_W  its sequence number
- retire_pc / retire_instr  out  PC_W  its PC / word
- retire_fetch_cyc  out  CYC_W  cycle_count when it was captured
- retire_cyc  out  CYC_W  cycle_count now (cycle it sits in WB)
- retire_stalls  out  STL_W  stall cycles spent in IF+ID
- cycle_count  out  CYC_W  free-running cycle counter
- in_flight  out  3  number of valid slots (0..5)
- retired_count  out  CYC_W  total retirements since reset

## Operation
- Five slot registers IF, ID, EX, MEM, WB. Each holds valid, seq, pc, instr, fetch_cyc, stalls.
- Normal edge (stall=0, flush=0):
  - IF <= new entry if fetch_en, else bubble.
  - ID <= IF, EX <= ID, MEM <= EX, WB <= MEM.
- Stall edge (stall=1; flush ignored):
  - IF and ID hold. The stalls field of each, if valid, increments and saturates at 2^STL_W-1.
  - EX <= bubble, MEM <= EX, WB <= MEM.
  - Fetch is not captured and seq does not advance.
- Flush edge (flush=1, stall=0):
  - ID <= bubble (the IF occupant is discarded).
  - IF <= new fetch as normal; EX/MEM/WB advance.
- New entry fields: seq = next_seq, then next_seq++ (mod 2^SEQ_W); fetch_cyc = cycle_count; stalls = 0.
- Retire outputs are combinational from the WB slot. retire_* data is don't-care when retire_valid=0; it is driven as 0 for cleanliness.
- retired_count increments on every edge where retire_valid=1.
- in_flight is the popcount of slot valids.

## Timing
- Reset: all slots invalid; next_seq=0; cycle_count=0; retired_count=0. All outputs read 0 in the cycle after the reset edge. rst overrides stall/flush.
- Reset mid-operation discards all in-flight tags; nothing retires for them.
- cycle_count increments on every non-reset edge, wrapping at 2^CYC_W.
- Latency: fetch presented in cycle c is in IF at c+1 and WB at c+5+S, with S = stall cycles.
  - For any un-flushed instruction: retire_cyc - retire_fetch_cyc = 5 + retire_stalls (until stalls saturate).
- First fetch after reset gets seq 0. Bubbles never consume seq numbers.
- A stall with IF/ID empty still holds and still inserts an EX bubble.
- Back-to-back stalls accumulate in the same IF/ID entries; the stall counter saturates and never wraps.

## Structure
- Package trace_pkg holds:
  - trace_slot_t struct (valid, seq, pc, instr, fetch_cyc, stalls), parameterised by package localparams matching the defaults;
  - stage_t enum {IF, ID, EX, MEM, WB};
  - the BUBBLE constant (all fields 0).
- One sub-module, trace_stage_reg: a single slot with load/hold/bubble/stall-increment controls, instantiated five times.

## Test plan
- Reset, then 8 cycles fetch_en=1 with pc=0,2,4…: retire_valid first high in cycle 5 with seq 0, pc 0, fetch_cyc 0, retire_cyc 5, stalls 0; then consecutive seq 1..3.
- Stall 2 cycles while seq 3 is in ID: seq 3 retires with stalls=2 and retire_cyc - fetch_cyc = 7; exactly two idle retire cycles precede it; seq 4 is not duplicated.
- Flush with seq 5 in IF: seq 5 never retires; seq 6 follows seq 4 after one idle retire cycle.
- stall=1 and flush=1 together: behaves as stall only; no instruction is lost.
- Hold stall for 10 cycles: retire_stalls saturates at 7; in_flight drops from 5 to 2.
- Assert rst with 5 in flight: in_flight=0, cycle_count=0, next retire is seq 0 at retire_cyc 5.
